// File: rtl/startup_gen_pkg.sv
// -----------------------------------------------------------------------------
// startup_gen_pkg
// Shared types and helpers for the start-up square-wave generator.
//   state_t    : generator FSM states (IDLE, HIGH, LOW, HOLD)
//   clamp_min  : raises a requested value to a lower bound
//   width_for  : bits needed to hold a value (used for width sanity checks)
//   DEF_*      : default MIN_HALF / MAX_PERIODS values
// -----------------------------------------------------------------------------
package startup_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam int DEF_MIN_HALF    = 2;
  localparam int DEF_MAX_PERIODS = 64;

  function automatic logic [31:0] clamp_min(input logic [31:0] value,
                                            input logic [31:0] floor_val);
    return (value < floor_val) ? floor_val : value;
  endfunction

  function automatic int width_for(input int value);
    return (value < 2) ? 1 : $clog2(value + 1);
  endfunction

endpackage

// File: rtl/startup_gen_if.sv
// -----------------------------------------------------------------------------
// startup_gen_if
// Bundle between the burst source (interrupter side) and the generator.
//   en        : burst enable
//   half_per  : requested half-period in clk cycles
//   gen       : square wave towards the output selector
//   busy      : generator not idle
//   per_done  : one-cycle pulse on the last cycle of each period
//   per_cnt   : periods completed in the current burst (saturating)
//   limit_hit : period cap reached, held until en drops
// master = side that drives en/half_per, slave = generator.
// -----------------------------------------------------------------------------
interface startup_gen_if #(
  parameter int HALF_W = 16,
  parameter int PER_W  = 8
) ();
  logic              en;
  logic [HALF_W-1:0] half_per;
  logic              gen;
  logic              busy;
  logic              per_done;
  logic [PER_W-1:0]  per_cnt;
  logic              limit_hit;

  modport master (
    output en, half_per,
    input  gen, busy, per_done, per_cnt, limit_hit
  );

  modport slave (
    input  en, half_per,
    output gen, busy, per_done, per_cnt, limit_hit
  );
endinterface

// File: rtl/startup_gen_halfper_timer.sv
// -----------------------------------------------------------------------------
// halfper_timer
// Loadable down-counter timing each half-period of the generated wave.
//   clk, rst_n  : clock / async active-low reset
//   i_load      : load i_load_val this edge (has priority over counting)
//   i_load_val  : value loaded (half-period length minus one)
//   o_zero      : counter currently at zero
//   o_count     : current counter value
// The counter parks at zero when not reloaded.
// -----------------------------------------------------------------------------
module halfper_timer #(
  parameter int HALF_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [HALF_W-1:0] i_load_val,
  output logic              o_zero,
  output logic [HALF_W-1:0] o_count
);

  logic [HALF_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero  = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/startup_gen.sv
// -----------------------------------------------------------------------------
// startup_gen
// Generates whole periods of a square wave for the output selector during
// start-up. Each period is hp cycles high followed by hp cycles low, where
// hp = max(half_per, MIN_HALF) is latched at the start of every period.
// Periods are never truncated except by reset.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : startup_gen_if slave (en, half_per in; gen, busy, per_done,
//            per_cnt, limit_hit out)
// Default half_per = 500 at CLK_MHZ = 100 gives 100 kHz.
// -----------------------------------------------------------------------------
module startup_gen
  import startup_gen_pkg::*;
#(
  parameter int CLK_MHZ     = 100,
  parameter int HALF_W      = 16,
  parameter int MIN_HALF    = DEF_MIN_HALF,
  parameter int MAX_PERIODS = DEF_MAX_PERIODS,
  parameter int PER_W       = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  startup_gen_if.slave bus
);

  // Elaboration-time parameter sanity
  if (MIN_HALF < 1) begin : g_chk_min_half
    $error("startup_gen: MIN_HALF must be at least 1");
  end
  if (PER_W < width_for(MAX_PERIODS)) begin : g_chk_per_w
    $error("startup_gen: PER_W too narrow for MAX_PERIODS");
  end
  if (CLK_MHZ < 1) begin : g_chk_clk
    $error("startup_gen: CLK_MHZ must be positive");
  end

  localparam logic [PER_W-1:0] MAX_P = PER_W'(MAX_PERIODS);

  state_t            r_state;
  logic              r_gen;
  logic              r_busy;
  logic              r_per_done;
  logic [PER_W-1:0]  r_per_cnt;
  logic              r_limit_hit;
  logic [HALF_W-1:0] r_hp_q;

  logic [HALF_W-1:0] w_hp;
  logic [HALF_W-1:0] w_count;
  logic              w_zero;
  logic              w_load;
  logic [HALF_W-1:0] w_load_val;
  logic [PER_W-1:0]  w_per_inc;
  logic              w_limit_reach;

  assign w_hp = HALF_W'(clamp_min(32'(bus.half_per), 32'(MIN_HALF)));

  // Saturating increment of the completed-period count
  assign w_per_inc     = (r_per_cnt == '1) ? r_per_cnt : r_per_cnt + 1'b1;
  assign w_limit_reach = (MAX_PERIODS != 0) && (w_per_inc == MAX_P);

  // Timer reload on each half-period boundary: a new period reloads from the
  // freshly clamped request, the high->low boundary reuses the latched value.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = w_hp - 1'b1;
    case (r_state)
      IDLE: begin
        if (bus.en && !r_limit_hit) w_load = 1'b1;
      end
      HIGH: begin
        if (w_zero) begin
          w_load     = 1'b1;
          w_load_val = r_hp_q - 1'b1;
        end
      end
      LOW: begin
        if (w_zero && !w_limit_reach && bus.en) w_load = 1'b1;
      end
      default: begin
        w_load = 1'b0;
      end
    endcase
  end

  halfper_timer #(
    .HALF_W (HALF_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_zero),
    .o_count    (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_gen       <= 1'b0;
      r_busy      <= 1'b0;
      r_per_done  <= 1'b0;
      r_per_cnt   <= '0;
      r_limit_hit <= 1'b0;
      r_hp_q      <= '0;
    end else begin
      r_per_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_gen <= 1'b0;
          if (bus.en && !r_limit_hit) begin
            r_state   <= HIGH;
            r_gen     <= 1'b1;
            r_busy    <= 1'b1;
            r_hp_q    <= w_hp;
            r_per_cnt <= '0;
          end
        end
        HIGH: begin
          if (w_zero) begin
            r_state    <= LOW;
            r_gen      <= 1'b0;
            // A one-cycle low half makes its first cycle the period's last
            r_per_done <= (r_hp_q == HALF_W'(1));
          end
        end
        LOW: begin
          if (w_zero) begin
            r_per_cnt <= w_per_inc;
            if (w_limit_reach) begin
              r_state     <= HOLD;
              r_limit_hit <= 1'b1;
            end else if (bus.en) begin
              r_state <= HIGH;
              r_gen   <= 1'b1;
              r_hp_q  <= w_hp;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else if (w_count == HALF_W'(1)) begin
            // Next cycle is the last low cycle of the period
            r_per_done <= 1'b1;
          end
        end
        HOLD: begin
          r_gen <= 1'b0;
          if (!bus.en) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_limit_hit <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gen   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gen       = r_gen;
  assign bus.busy      = r_busy;
  assign bus.per_done  = r_per_done;
  assign bus.per_cnt   = r_per_cnt;
  assign bus.limit_hit = r_limit_hit;

endmodule

// File: tb/tb_startup_gen.sv
// -----------------------------------------------------------------------------
// tb_startup_gen
// Directed bench for startup_gen. Instance A uses the default period cap
// (64); instance B uses MAX_PERIODS=3 for the cap/HOLD scenario. Outputs are
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_startup_gen;

  logic clk;
  logic rst_n;
  int   n_err;
  int   n_checks;

  startup_gen_if #(.HALF_W(16), .PER_W(8)) aif ();
  startup_gen_if #(.HALF_W(16), .PER_W(8)) bif ();

  startup_gen #(
    .CLK_MHZ(100), .HALF_W(16), .MIN_HALF(2), .MAX_PERIODS(64), .PER_W(8)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (aif)
  );

  startup_gen #(
    .CLK_MHZ(100), .HALF_W(16), .MIN_HALF(2), .MAX_PERIODS(3), .PER_W(8)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Check n high cycles, starting at the current falling edge
  task automatic exp_high(input string tag, input int s, input int n);
    for (int k = 0; k < n; k++) begin
      chk({tag, ".gen_hi"}, (s != 0) ? bif.gen : aif.gen, 1);
      chk({tag, ".pd_hi"},  (s != 0) ? bif.per_done : aif.per_done, 0);
      chk({tag, ".busy_hi"}, (s != 0) ? bif.busy : aif.busy, 1);
      @(negedge clk);
    end
    $display("step %s: %0d high cycles checked", tag, n);
  endtask

  // Check n low cycles; per_done expected on the last one only
  task automatic exp_low(input string tag, input int s, input int n);
    for (int k = 0; k < n; k++) begin
      chk({tag, ".gen_lo"}, (s != 0) ? bif.gen : aif.gen, 0);
      chk({tag, ".pd_lo"},  (s != 0) ? bif.per_done : aif.per_done, (k == n - 1) ? 1 : 0);
      chk({tag, ".busy_lo"}, (s != 0) ? bif.busy : aif.busy, 1);
      @(negedge clk);
    end
    $display("step %s: %0d low cycles checked", tag, n);
  endtask

  task automatic exp_idle_a(input string tag);
    chk({tag, ".gen_idle"}, aif.gen, 0);
    chk({tag, ".busy_idle"}, aif.busy, 0);
    chk({tag, ".pd_idle"}, aif.per_done, 0);
  endtask

  initial begin
    n_err    = 0;
    n_checks = 0;
    rst_n    = 1'b0;
    aif.en = 1'b0; aif.half_per = 16'd5;
    bif.en = 1'b0; bif.half_per = 16'd2;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst.a_gen", aif.gen, 0);
    chk("rst.a_busy", aif.busy, 0);
    chk("rst.a_pd", aif.per_done, 0);
    chk("rst.a_cnt", aif.per_cnt, 0);
    chk("rst.a_lim", aif.limit_hit, 0);
    chk("rst.b_gen", bif.gen, 0);
    chk("rst.b_lim", bif.limit_hit, 0);
    rst_n = 1'b1;
    @(negedge clk);
    exp_idle_a("rst.rel");
    $display("step reset: done");

    // T1: half_per=5, en held -> 5/5 periods, per_cnt 1,2,3
    aif.half_per = 16'd5;
    aif.en = 1'b1;
    chk("t1.gen_before_edge", aif.gen, 0);
    @(negedge clk);
    chk("t1.cnt_start", aif.per_cnt, 0);
    for (int p = 0; p < 3; p++) begin
      exp_high("t1", 0, 5);
      exp_low("t1", 0, 5);
      chk("t1.per_cnt", aif.per_cnt, p + 1);
    end
    // Drop en on the first cycle of period 4: that period still completes
    aif.en = 1'b0;
    exp_high("t1.drop", 0, 5);
    exp_low("t1.drop", 0, 5);
    exp_idle_a("t1.end");
    chk("t1.cnt_end", aif.per_cnt, 4);

    // T2: half_per 0 and 1 clamp to 2
    aif.half_per = 16'd0;
    aif.en = 1'b1;
    @(negedge clk);
    exp_high("t2.hp0", 0, 2);
    exp_low("t2.hp0", 0, 2);
    exp_high("t2.hp0", 0, 2);
    aif.en = 1'b0;
    exp_low("t2.hp0", 0, 2);
    exp_idle_a("t2.hp0");
    aif.half_per = 16'd1;
    aif.en = 1'b1;
    @(negedge clk);
    exp_high("t2.hp1", 0, 2);
    aif.en = 1'b0;
    exp_low("t2.hp1", 0, 2);
    exp_idle_a("t2.hp1");

    // T3: en dropped on 2nd HIGH cycle, half_per=8
    aif.half_per = 16'd8;
    aif.en = 1'b1;
    @(negedge clk);
    exp_high("t3", 0, 1);
    aif.en = 1'b0;
    exp_high("t3", 0, 7);
    exp_low("t3", 0, 8);
    exp_idle_a("t3.end");
    @(negedge clk);
    exp_idle_a("t3.stay");

    // T5: half_per 5 -> 7 mid-HIGH takes effect next period
    aif.half_per = 16'd5;
    aif.en = 1'b1;
    @(negedge clk);
    exp_high("t5", 0, 2);
    aif.half_per = 16'd7;
    exp_high("t5", 0, 3);
    exp_low("t5", 0, 5);
    exp_high("t5", 0, 7);
    aif.en = 1'b0;
    exp_low("t5", 0, 7);
    exp_idle_a("t5.end");

    // T4: instance B, cap of 3 periods
    bif.half_per = 16'd2;
    bif.en = 1'b1;
    @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      exp_high("t4", 1, 2);
      exp_low("t4", 1, 2);
      chk("t4.per_cnt", bif.per_cnt, p + 1);
      chk("t4.limit", bif.limit_hit, (p == 2) ? 1 : 0);
    end
    for (int k = 0; k < 4; k++) begin
      chk("t4.hold_gen", bif.gen, 0);
      chk("t4.hold_busy", bif.busy, 1);
      chk("t4.hold_lim", bif.limit_hit, 1);
      @(negedge clk);
    end
    $display("step t4: hold checked");
    bif.en = 1'b0;
    @(negedge clk);
    chk("t4.rel_lim", bif.limit_hit, 0);
    chk("t4.rel_busy", bif.busy, 0);
    bif.en = 1'b1;
    @(negedge clk);
    chk("t4.new_cnt", bif.per_cnt, 0);
    exp_high("t4.new", 1, 2);
    bif.en = 1'b0;
    exp_low("t4.new", 1, 2);
    chk("t4.new_cnt_end", bif.per_cnt, 1);
    chk("t4.new_busy_end", bif.busy, 0);

    // T6: async reset in mid-HIGH of the 2nd period
    aif.half_per = 16'd5;
    aif.en = 1'b1;
    @(negedge clk);
    exp_high("t6", 0, 5);
    exp_low("t6", 0, 5);
    chk("t6.cnt_pre", aif.per_cnt, 1);
    exp_high("t6", 0, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6.rst_gen", aif.gen, 0);
    chk("t6.rst_busy", aif.busy, 0);
    chk("t6.rst_cnt", aif.per_cnt, 0);
    chk("t6.rst_pd", aif.per_done, 0);
    chk("t6.rst_lim", aif.limit_hit, 0);
    $display("step t6: async reset checked");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6.restart_cnt", aif.per_cnt, 0);
    exp_high("t6.restart", 0, 5);
    aif.en = 1'b0;
    exp_low("t6.restart", 0, 5);
    exp_idle_a("t6.end");
    chk("t6.cnt_end", aif.per_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
